// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator sequencing controller.
//   - calc_state_t : power/operation state encoding
//   - CALC_WIDTH_DEFAULT / CALC_SYNC_DEFAULT : default parameter values
//   - BTN_* : bit positions of each button in the 4-bit button vector
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_WIDTH_DEFAULT = 7;
    localparam int CALC_SYNC_DEFAULT  = 2;

    localparam int BTN_NUM   = 4;
    localparam int BTN_LIG   = 0;
    localparam int BTN_SOMA  = 1;
    localparam int BTN_SUB   = 2;
    localparam int BTN_MULTI = 3;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_IDLE = 3'd1,
        ST_ADD  = 3'd2,
        ST_SUB  = 3'd3,
        ST_MUL  = 3'd4,
        ST_SHOW = 3'd5
    } calc_state_t;

endpackage

// File: rtl/calc_btn_cond.sv
// ---------------------------------------------------------------------------
// calc_btn_cond
// Conditions a vector of active-low push-buttons: a SYNC_STAGES-deep
// synchronizer followed by a registered falling-edge pulse generator.
// A held button yields exactly one single-cycle pulse; no debounce.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_btn_n  in   N  raw active-low button levels (asynchronous)
//   o_pulse  out  N  one-cycle press pulses (registered)
// ---------------------------------------------------------------------------
module calc_btn_cond
    import calc_pkg::*;
#(
    parameter int N           = BTN_NUM,
    parameter int SYNC_STAGES = CALC_SYNC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_btn_n,
    output logic [N-1:0] o_pulse
);

    // All stages reset to released (1) so reset release never looks like a press.
    logic [N-1:0] r_sync [SYNC_STAGES];
    logic [N-1:0] r_prev;
    logic [N-1:0] r_pulse;
    logic [N-1:0] w_sync_last;

    assign w_sync_last = r_sync[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous button levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '1;
            end
        end else begin
            r_sync[0] <= i_btn_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Falling-edge detect on the synchronized level, registered as a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= '1;
            r_pulse <= '0;
        end else begin
            r_prev  <= w_sync_last;
            r_pulse <= r_prev & ~w_sync_last;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/calc_ctrl.sv
// ---------------------------------------------------------------------------
// calc_ctrl
// Sequencing controller for the calculator datapath. Conditions the four
// push-buttons, runs the power/operation FSM, latches operands on each
// request and produces sign-magnitude results (add/sub in one cycle,
// multiply through a WIDTH-cycle shift-add engine).
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   A, B     in   WIDTH    unsigned operands
//   b_lig    in   power toggle button (active-low)
//   b_soma   in   add request button (active-low)
//   b_sub    in   subtract request button (active-low)
//   b_multi  in   multiply request button (active-low)
//   Y        out  2*WIDTH  result magnitude
//   sinal    out  result sign (1 = negative)
//   EN       out  display enable, 1 while powered
//   busy     out  operation in progress
//   done     out  one-cycle pulse when Y/sinal carry a new result
// ---------------------------------------------------------------------------
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH       = CALC_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = CALC_SYNC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               b_lig,
    input  logic               b_soma,
    input  logic               b_sub,
    input  logic               b_multi,
    output logic [2*WIDTH-1:0] Y,
    output logic               sinal,
    output logic               EN,
    output logic               busy,
    output logic               done
);

    localparam int YW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    // Button conditioning
    logic [BTN_NUM-1:0] w_btn_n;
    logic [BTN_NUM-1:0] w_pulse;

    assign w_btn_n[BTN_LIG]   = b_lig;
    assign w_btn_n[BTN_SOMA]  = b_soma;
    assign w_btn_n[BTN_SUB]   = b_sub;
    assign w_btn_n[BTN_MULTI] = b_multi;

    calc_btn_cond #(
        .N           (BTN_NUM),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (w_btn_n),
        .o_pulse (w_pulse)
    );

    // Registers
    calc_state_t      r_state;
    logic [YW-1:0]    r_y;
    logic             r_sinal;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_mplier;
    logic [YW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;

    // Priority encoder: lig > soma > sub > multi; losers in the same cycle are dropped.
    logic w_ev_lig;
    logic w_ev_soma;
    logic w_ev_sub;
    logic w_ev_multi;

    always_comb begin
        w_ev_lig   = 1'b0;
        w_ev_soma  = 1'b0;
        w_ev_sub   = 1'b0;
        w_ev_multi = 1'b0;
        if (w_pulse[BTN_LIG]) begin
            w_ev_lig = 1'b1;
        end else if (w_pulse[BTN_SOMA]) begin
            w_ev_soma = 1'b1;
        end else if (w_pulse[BTN_SUB]) begin
            w_ev_sub = 1'b1;
        end else if (w_pulse[BTN_MULTI]) begin
            w_ev_multi = 1'b1;
        end else begin
            w_ev_multi = 1'b0;
        end
    end

    // Arithmetic on the latched operands (never on live A/B).
    logic [YW-1:0]    w_sum;
    logic             w_b_gt_a;
    logic [WIDTH-1:0] w_diff;
    logic [YW-1:0]    w_diff_y;
    logic [YW-1:0]    w_partial;
    logic [YW-1:0]    w_acc_next;
    logic             w_last_iter;

    // Datapath: sum, sign-magnitude difference and one shift-add step.
    always_comb begin
        w_sum    = YW'(r_op_a) + YW'(r_op_b);
        w_b_gt_a = (r_op_b > r_op_a);
        if (w_b_gt_a) begin
            w_diff = r_op_b - r_op_a;
        end else begin
            w_diff = r_op_a - r_op_b;
        end
        w_diff_y = YW'(w_diff);
        // Multiplicand is shifted by the iteration index rather than kept in a shift register.
        if (r_mplier[0]) begin
            w_partial = YW'(r_op_a) << r_cnt;
        end else begin
            w_partial = '0;
        end
        w_acc_next  = r_acc + w_partial;
        w_last_iter = (r_cnt == CW'(WIDTH - 1));
    end

    // Power/operation FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_OFF;
            r_y      <= '0;
            r_sinal  <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (w_ev_lig) begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b1;
                        r_y     <= '0;
                        r_sinal <= 1'b0;
                    end else begin
                        r_state <= ST_OFF;
                    end
                end

                ST_IDLE, ST_SHOW: begin
                    if (w_ev_lig) begin
                        r_state <= ST_OFF;
                        r_en    <= 1'b0;
                        r_y     <= '0;
                        r_sinal <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_ev_soma || w_ev_sub || w_ev_multi) begin
                        if (w_ev_soma) begin
                            r_state <= ST_ADD;
                        end else if (w_ev_sub) begin
                            r_state <= ST_SUB;
                        end else begin
                            r_state <= ST_MUL;
                        end
                        r_busy   <= 1'b1;
                        r_op_a   <= A;
                        r_op_b   <= B;
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_state <= r_state;
                    end
                end

                ST_ADD, ST_SUB: begin
                    if (w_ev_lig) begin
                        r_state <= ST_OFF;
                        r_en    <= 1'b0;
                        r_y     <= '0;
                        r_sinal <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        if (r_state == ST_ADD) begin
                            r_y     <= w_sum;
                            r_sinal <= 1'b0;
                        end else begin
                            r_y     <= w_diff_y;
                            r_sinal <= w_b_gt_a;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_SHOW;
                    end
                end

                ST_MUL: begin
                    if (w_ev_lig) begin
                        r_state <= ST_OFF;
                        r_en    <= 1'b0;
                        r_y     <= '0;
                        r_sinal <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        if (w_last_iter) begin
                            r_y     <= w_acc_next;
                            r_sinal <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_SHOW;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_OFF;
                    r_en    <= 1'b0;
                    r_y     <= '0;
                    r_sinal <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Y     = r_y;
    assign sinal = r_sinal;
    assign EN    = r_en;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_calc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_ctrl
// Self-checking bench for calc_ctrl (WIDTH=7, SYNC_STAGES=2). Expected
// results are queued when an operation is requested and popped by a
// monitor whenever done pulses. Timing is measured in clock edges from
// the moment a button is driven low (1 time unit after a rising edge):
// press pulse after edge 3, state change at edge 4, add/sub done after
// edge 5, multiply busy after edges 4..10 and done after edge 11.
// ---------------------------------------------------------------------------
module tb_calc_ctrl;

    localparam logic [3:0] M_NONE  = 4'b0000;
    localparam logic [3:0] M_LIG   = 4'b0001;
    localparam logic [3:0] M_SOMA  = 4'b0010;
    localparam logic [3:0] M_SUB   = 4'b0100;
    localparam logic [3:0] M_MULTI = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  A;
    logic [6:0]  B;
    logic        b_lig;
    logic        b_soma;
    logic        b_sub;
    logic        b_multi;
    logic [13:0] Y;
    logic        sinal;
    logic        EN;
    logic        busy;
    logic        done;

    calc_ctrl #(.WIDTH(7), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .b_lig   (b_lig),
        .b_soma  (b_soma),
        .b_sub   (b_sub),
        .b_multi (b_multi),
        .Y       (Y),
        .sinal   (sinal),
        .EN      (EN),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] y;
        logic        s;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Measurements filled in by run_op
    int done_k, done_last_k, done_cnt, busy_cnt, busy_first, en_chg_k, en_chgs;

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done: done=1 with nothing queued, Y=%0d sinal=%0b", Y, sinal);
                end else begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (Y !== mon_e.y) begin
                        errors++;
                        $display("FAIL sb_y: Y=%0d expected %0d", Y, mon_e.y);
                    end
                    checks++;
                    if (sinal !== mon_e.s) begin
                        errors++;
                        $display("FAIL sb_sinal: sinal=%0b expected %0b", sinal, mon_e.s);
                    end
                end
            end
        end
    end

    task automatic drive_btns(input logic [3:0] m);
        b_lig   = ~m[0];
        b_soma  = ~m[1];
        b_sub   = ~m[2];
        b_multi = ~m[3];
    endtask

    // Press m1 now (held for 'hold' edges), optionally press m2 after edge k2,
    // optionally change A after edge chg_k; observe max_k edges.
    task automatic run_op(input logic [3:0] m1, input int hold, input logic [3:0] m2,
                          input int k2, input int chg_k, input logic [6:0] chg_a,
                          input int max_k);
        logic [3:0] held;
        logic       en0;
        done_k = 0; done_last_k = 0; done_cnt = 0; busy_cnt = 0;
        busy_first = 0; en_chg_k = 0; en_chgs = 0;
        en0  = EN;
        held = m1;
        drive_btns(held);
        for (int k = 1; k <= max_k; k++) begin
            @(posedge clk);
            #1;
            if (EN !== en0) begin
                en_chgs++;
                if (en_chg_k == 0) en_chg_k = k;
                en0 = EN;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
                done_last_k = k;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = k;
            end
            if (k == hold) held = held & ~m1;
            if (k2 > 0 && k == k2) held = held | m2;
            if (k2 > 0 && k == k2 + hold) held = held & ~m2;
            if (k == chg_k) A = chg_a;
            drive_btns(held);
        end
        drive_btns(M_NONE);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 7'd0;
        B = 7'd0;
        drive_btns(M_NONE);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Y !== 14'd0)   begin errors++; $display("FAIL rst_y: Y=%0d expected 0", Y); end
        checks++; if (sinal !== 1'b0) begin errors++; $display("FAIL rst_sinal: sinal=%0b expected 0", sinal); end
        checks++; if (EN !== 1'b0)    begin errors++; $display("FAIL rst_en: EN=%0b expected 0", EN); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy: busy=%0b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_done: done=%0b expected 0", done); end
        rst_n = 1'b1;
        run_op(M_NONE, 0, M_NONE, 0, 0, 7'd0, 5);
        checks++; if (en_chgs !== 0)  begin errors++; $display("FAIL rst_release_en: EN changes=%0d expected 0", en_chgs); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_release_done: done pulses=%0d expected 0", done_cnt); end
    endtask

    task automatic test_power();
        run_op(M_LIG, 10, M_NONE, 0, 0, 7'd0, 12);
        checks++; if (en_chg_k !== 4) begin errors++; $display("FAIL pwr_on_latency: EN rose at edge %0d expected 4", en_chg_k); end
        checks++; if (en_chgs !== 1)  begin errors++; $display("FAIL pwr_on_single: EN changes=%0d expected 1", en_chgs); end
        checks++; if (EN !== 1'b1)    begin errors++; $display("FAIL pwr_on_en: EN=%0b expected 1", EN); end
        checks++; if (Y !== 14'd0)    begin errors++; $display("FAIL pwr_on_y: Y=%0d expected 0", Y); end
        run_op(M_LIG, 3, M_NONE, 0, 0, 7'd0, 8);
        checks++; if (en_chg_k !== 4) begin errors++; $display("FAIL pwr_off_latency: EN fell at edge %0d expected 4", en_chg_k); end
        checks++; if (EN !== 1'b0)    begin errors++; $display("FAIL pwr_off_en: EN=%0b expected 0", EN); end
        run_op(M_LIG, 3, M_NONE, 0, 0, 7'd0, 8);
        checks++; if (EN !== 1'b1)    begin errors++; $display("FAIL pwr_on2_en: EN=%0b expected 1", EN); end
    endtask

    task automatic test_add();
        A = 7'd100;
        B = 7'd27;
        sb_q.push_back('{y: 14'd127, s: 1'b0});
        run_op(M_SOMA, 3, M_NONE, 0, 0, 7'd0, 10);
        checks++; if (done_k !== 5)   begin errors++; $display("FAIL add_latency: done at edge %0d expected 5", done_k); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL add_done_width: done pulses=%0d expected 1", done_cnt); end
        checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL add_busy: busy cycles=%0d expected 1", busy_cnt); end
        checks++; if (Y !== 14'd127)  begin errors++; $display("FAIL add_y_hold: Y=%0d expected 127", Y); end
    endtask

    task automatic test_sub();
        logic [6:0]  ta [3] = '{7'd5, 7'd9, 7'd50};
        logic [6:0]  tb [3] = '{7'd9, 7'd5, 7'd50};
        logic [13:0] ty [3] = '{14'd4, 14'd4, 14'd0};
        logic        ts [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            A = ta[i];
            B = tb[i];
            sb_q.push_back('{y: ty[i], s: ts[i]});
            run_op(M_SUB, 3, M_NONE, 0, 0, 7'd0, 10);
            checks++; if (done_k !== 5)   begin errors++; $display("FAIL sub_latency[%0d]: done at edge %0d expected 5", i, done_k); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sub_done[%0d]: done pulses=%0d expected 1", i, done_cnt); end
        end
    endtask

    task automatic test_mul();
        logic [6:0]  ta [3] = '{7'd0, 7'd13, 7'd1};
        logic [6:0]  tb [3] = '{7'd5, 7'd11, 7'd127};
        logic [13:0] ty [3] = '{14'd0, 14'd143, 14'd127};
        A = 7'd127;
        B = 7'd127;
        sb_q.push_back('{y: 14'd16129, s: 1'b0});
        // A drops to 0 right after the operands are latched.
        run_op(M_MULTI, 3, M_NONE, 0, 4, 7'd0, 14);
        checks++; if (busy_first !== 4) begin errors++; $display("FAIL mul_busy_start: busy at edge %0d expected 4", busy_first); end
        checks++; if (busy_cnt !== 7)   begin errors++; $display("FAIL mul_busy_len: busy cycles=%0d expected 7", busy_cnt); end
        checks++; if (done_k !== 11)    begin errors++; $display("FAIL mul_latency: done at edge %0d expected 11", done_k); end
        checks++; if (done_cnt !== 1)   begin errors++; $display("FAIL mul_done_width: done pulses=%0d expected 1", done_cnt); end
        for (int i = 0; i < 3; i++) begin
            A = ta[i];
            B = tb[i];
            sb_q.push_back('{y: ty[i], s: 1'b0});
            run_op(M_MULTI, 3, M_NONE, 0, 0, 7'd0, 14);
            checks++; if (done_k !== 11) begin errors++; $display("FAIL mul_tab_latency[%0d]: done at edge %0d expected 11", i, done_k); end
        end
    endtask

    task automatic test_abort();
        A = 7'd3;
        B = 7'd4;
        run_op(M_MULTI, 3, M_NONE, 0, 0, 7'd0, 6);
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL abort_busy_before: busy=%0b expected 1", busy); end
        run_op(M_LIG, 3, M_NONE, 0, 0, 7'd0, 10);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: done pulses=%0d expected 0", done_cnt); end
        checks++; if (en_chg_k !== 4) begin errors++; $display("FAIL abort_en_edge: EN fell at edge %0d expected 4", en_chg_k); end
        checks++; if (busy_cnt !== 3) begin errors++; $display("FAIL abort_busy_len: busy cycles=%0d expected 3", busy_cnt); end
        checks++; if (EN !== 1'b0)    begin errors++; $display("FAIL abort_en: EN=%0b expected 0", EN); end
        checks++; if (Y !== 14'd0)    begin errors++; $display("FAIL abort_y: Y=%0d expected 0", Y); end
        checks++; if (sinal !== 1'b0) begin errors++; $display("FAIL abort_sinal: sinal=%0b expected 0", sinal); end
        run_op(M_SOMA, 3, M_NONE, 0, 0, 7'd0, 10);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL off_soma_done: done pulses=%0d expected 0", done_cnt); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL off_soma_busy: busy cycles=%0d expected 0", busy_cnt); end
        checks++; if (en_chgs !== 0)  begin errors++; $display("FAIL off_soma_en: EN changes=%0d expected 0", en_chgs); end
        checks++; if (Y !== 14'd0)    begin errors++; $display("FAIL off_soma_y: Y=%0d expected 0", Y); end
    endtask

    task automatic test_priority();
        run_op(M_LIG, 3, M_NONE, 0, 0, 7'd0, 8);
        checks++; if (EN !== 1'b1)    begin errors++; $display("FAIL prio_pwr_on: EN=%0b expected 1", EN); end
        A = 7'd10;
        B = 7'd3;
        run_op(M_LIG | M_MULTI, 3, M_NONE, 0, 0, 7'd0, 12);
        checks++; if (EN !== 1'b0)    begin errors++; $display("FAIL prio_lig_multi_en: EN=%0b expected 0", EN); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL prio_lig_multi_busy: busy cycles=%0d expected 0", busy_cnt); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL prio_lig_multi_done: done pulses=%0d expected 0", done_cnt); end
        run_op(M_LIG, 3, M_NONE, 0, 0, 7'd0, 8);
        sb_q.push_back('{y: 14'd13, s: 1'b0});
        run_op(M_SOMA | M_SUB, 3, M_NONE, 0, 0, 7'd0, 10);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL prio_soma_sub_done: done pulses=%0d expected 1", done_cnt); end
        checks++; if (done_k !== 5)   begin errors++; $display("FAIL prio_soma_sub_latency: done at edge %0d expected 5", done_k); end
    endtask

    task automatic test_back_to_back();
        A = 7'd20;
        B = 7'd7;
        sb_q.push_back('{y: 14'd27, s: 1'b0});
        sb_q.push_back('{y: 14'd13, s: 1'b0});
        // Sub pulse lands in the cycle the add's done is high.
        run_op(M_SOMA, 3, M_SUB, 2, 0, 7'd0, 12);
        checks++; if (done_cnt !== 2)    begin errors++; $display("FAIL b2b_done_cnt: done pulses=%0d expected 2", done_cnt); end
        checks++; if (done_k !== 5)      begin errors++; $display("FAIL b2b_first: done at edge %0d expected 5", done_k); end
        checks++; if (done_last_k !== 7) begin errors++; $display("FAIL b2b_second: done at edge %0d expected 7", done_last_k); end
        checks++; if (busy_cnt !== 2)    begin errors++; $display("FAIL b2b_busy: busy cycles=%0d expected 2", busy_cnt); end
    endtask

    task automatic test_async_reset();
        A = 7'd3;
        B = 7'd4;
        run_op(M_MULTI, 3, M_NONE, 0, 0, 7'd0, 6);
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL arst_busy_before: busy=%0b expected 1", busy); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (Y !== 14'd0)    begin errors++; $display("FAIL arst_y: Y=%0d expected 0", Y); end
        checks++; if (EN !== 1'b0)    begin errors++; $display("FAIL arst_en: EN=%0b expected 0", EN); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL arst_busy: busy=%0b expected 0", busy); end
        checks++; if (sinal !== 1'b0) begin errors++; $display("FAIL arst_sinal: sinal=%0b expected 0", sinal); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(M_NONE, 0, M_NONE, 0, 0, 7'd0, 5);
        checks++; if (en_chgs !== 0)  begin errors++; $display("FAIL arst_release_en: EN changes=%0d expected 0", en_chgs); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL arst_release_done: done pulses=%0d expected 0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_power();
        test_add();
        test_sub();
        test_mul();
        test_abort();
        test_priority();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
